// File: rtl/thorkn_audiochip_v2_if.sv
// Parallel register-write bus and pad outputs of the audio chip.
// The master side (tile harness or bench) drives enable, write data and
// address/strobe. The slave side (the sound generator) returns the
// audio/status byte and the bidirectional pad controls.
interface thorkn_audiochip_v2_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/thorkn_audiochip_v2.sv
// Three-voice programmable sound generator.
// Each voice has a 16-bit phase accumulator, a square/saw/triangle/noise
// waveform and a 4-bit volume. The voices are summed into an 8-bit sample
// that drives a PWM audio pin. Voice registers are loaded one byte per
// rising edge of the write strobe on uio_in[4].
// The reset input keeps its legacy name rst_n but is active-high.
module thorkn_audiochip_v2 #(
  parameter int          NUM_VOICES = 3,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input logic              clk,
  input logic              rst_n,
  thorkn_audiochip_v2_if.slave bus
);

  localparam logic [3:0] ADDR_GLOBAL = 4'd9;

  // ---------------------------------------------------------------------
  // Register file and write decode
  // ---------------------------------------------------------------------
  logic       we_prev_q;
  logic       wr_en;
  logic [3:0] wr_addr;

  logic [7:0] freq_lo_q [NUM_VOICES];
  logic [7:0] freq_hi_q [NUM_VOICES];
  logic [7:0] ctrl_q    [NUM_VOICES];
  logic       mute_q;

  // One write per strobe pulse: only the first cycle of a high strobe counts.
  assign wr_en   = bus.uio_in[4] & ~we_prev_q;
  assign wr_addr = bus.uio_in[3:0];

  // Register file: strobe edge tracking and byte writes. Writes are not
  // gated by ena so the host can program voices while the engine is paused.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      we_prev_q <= 1'b0;
      mute_q    <= 1'b0;
      // NOTE: the register file is only nine bytes of flops, so every entry
      // is cleared on reset; a silent, known power-up voice setting matters
      // more than the reset fan-out.
      for (int v = 0; v < NUM_VOICES; v++) begin
        freq_lo_q[v] <= 8'h00;
        freq_hi_q[v] <= 8'h00;
        ctrl_q[v]    <= 8'h00;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples values from before the edge, independent of statement order.
      we_prev_q <= bus.uio_in[4];
      if (wr_en) begin
        for (int v = 0; v < NUM_VOICES; v++) begin
          if (wr_addr == 4'(3 * v))     freq_lo_q[v] <= bus.ui_in;
          if (wr_addr == 4'(3 * v + 1)) freq_hi_q[v] <= bus.ui_in;
          if (wr_addr == 4'(3 * v + 2)) ctrl_q[v]    <= bus.ui_in;
        end
        if (wr_addr == ADDR_GLOBAL) mute_q <= bus.ui_in[0];
        // Addresses 10..15 match nothing and are dropped.
      end
    end
  end

  // ---------------------------------------------------------------------
  // Voice datapath
  // ---------------------------------------------------------------------
  logic [16:0] acc     [NUM_VOICES];
  logic [15:0] phase_q [NUM_VOICES];
  logic [15:0] phase_d [NUM_VOICES];
  logic        carry   [NUM_VOICES];
  logic [15:0] lfsr_q  [NUM_VOICES];
  logic [15:0] lfsr_d  [NUM_VOICES];
  logic [7:0]  wave    [NUM_VOICES];
  logic [7:0]  level   [NUM_VOICES];

  // Next phase, accumulator carry and next LFSR state for every voice.
  // The LFSR is a right-shifting Fibonacci register with taps 16,14,13,11
  // and advances once per phase wrap, so noise pitch follows freq.
  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      acc[v]     = {1'b0, phase_q[v]} + {1'b0, freq_hi_q[v], freq_lo_q[v]};
      phase_d[v] = acc[v][15:0];
      carry[v]   = acc[v][16];
      lfsr_d[v]  = lfsr_q[v];
      if (carry[v]) begin
        lfsr_d[v] = {lfsr_q[v][0] ^ lfsr_q[v][2] ^ lfsr_q[v][3] ^ lfsr_q[v][5],
                     lfsr_q[v][15:1]};
      end
    end
  end

  // Waveform shaping and volume scaling per voice.
  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      // NOTE: every combinational output gets a default before the case so
      // no path leaves it unassigned, which would otherwise infer a latch.
      wave[v] = 8'h00;
      unique case (ctrl_q[v][1:0])
        2'd0: wave[v] = phase_q[v][15] ? 8'h00 : 8'hFF;
        2'd1: wave[v] = phase_q[v][15:8];
        2'd2: wave[v] = phase_q[v][15] ? ~phase_q[v][14:7] : phase_q[v][14:7];
        2'd3: wave[v] = lfsr_q[v][7:0];
        default: wave[v] = 8'h00;
      endcase
      // 8-bit wave times 4-bit volume, top 8 of 12 bits kept (max 239).
      level[v] = 8'((12'(wave[v]) * 12'(ctrl_q[v][7:4])) >> 4);
    end
  end

  // ---------------------------------------------------------------------
  // Mixer
  // ---------------------------------------------------------------------
  logic [9:0] sum;
  logic [7:0] mix;

  // Sum the voices into 10 bits and keep the top 8; mute forces silence.
  always_comb begin
    sum = 10'd0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      sum = sum + 10'(level[v]);
    end
    mix = mute_q ? 8'h00 : sum[9:2];
  end

  // ---------------------------------------------------------------------
  // Oscillator state and PWM output stage
  // ---------------------------------------------------------------------
  logic [7:0] pwm_cnt_q;
  logic [7:0] mix_reg_q;
  logic       pwm_q;

  // Time-base state: advances only while ena is high, holds otherwise.
  // mix_reg is reloaded only at the end of a PWM period so each 256-cycle
  // period carries a single duty value.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        phase_q[v] <= 16'h0000;
        lfsr_q[v]  <= LFSR_SEED;
      end
      pwm_cnt_q <= 8'h00;
      mix_reg_q <= 8'h00;
      pwm_q     <= 1'b0;
    end else if (bus.ena) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        phase_q[v] <= phase_d[v];
        lfsr_q[v]  <= lfsr_d[v];
      end
      pwm_cnt_q <= pwm_cnt_q + 8'd1;
      if (pwm_cnt_q == 8'hFF) mix_reg_q <= mix;
      pwm_q <= (pwm_cnt_q < mix_reg_q);
    end
  end

  // Pad outputs: PWM bit, voice phase MSBs and the upper nibble of the
  // current sample; the bidirectional pins are permanently inputs.
  assign bus.uo_out  = {mix_reg_q[7:4], phase_q[2][15], phase_q[1][15],
                        phase_q[0][15], pwm_q};
  assign bus.uio_out = 8'h00;
  assign bus.uio_oe  = 8'h00;

  // Address bits [7:5] and CTRL[3:2] carry no function.
  logic unused_bits;
  assign unused_bits = &{1'b0, bus.uio_in[7:5], ctrl_q[0][3:2],
                         ctrl_q[1][3:2], ctrl_q[2][3:2]};

endmodule

// File: tb/tb_thorkn_audiochip_v2.sv
// Scoreboard bench for the three-voice sound generator. Stimulus pushes
// expected output items tagged with the cycle at which they apply; a
// monitor samples the pads on every falling edge, measures PWM duty per
// 256-cycle period, and pops/compares items when their cycle arrives.
module tb_thorkn_audiochip_v2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  thorkn_audiochip_v2_if bus();

  thorkn_audiochip_v2 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          at_edge;
    bit          is_duty;
    logic [23:0] mask;
    logic [23:0] val;
    int          duty;
    logic [3:0]  nib;
  } item_t;

  item_t sb[$];
  int    checks = 0;
  int    errors = 0;

  // cyc: rising edges since reset; en_cnt: enabled edges (== pwm_cnt).
  int cyc;
  int en_cnt;
  always @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cyc    <= 0;
      en_cnt <= 0;
    end else begin
      cyc <= cyc + 1;
      if (bus.ena) en_cnt <= en_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: PWM duty measurement plus scoreboard pop/compare.
  initial begin
    int         duty_acc   = 0;
    int         last_duty  = 0;
    logic [3:0] nib_start  = 4'h0;
    logic [3:0] last_nib   = 4'h0;
    item_t      it;
    forever begin
      @(negedge clk);
      if (bus.uo_out[0] === 1'b1) duty_acc++;
      if (en_cnt % 256 == 0) begin
        last_duty = duty_acc;
        last_nib  = nib_start;
        duty_acc  = 0;
        nib_start = bus.uo_out[7:4];
      end
      while (sb.size() > 0 && sb[0].at_edge <= cyc) begin
        it = sb.pop_front();
        if (it.at_edge < cyc) begin
          check({it.name, "_missed"}, 32'(cyc), 32'(it.at_edge));
        end else if (it.is_duty) begin
          check({it.name, "_duty"}, 32'(last_duty), 32'(it.duty));
          check({it.name, "_nib"}, 32'(last_nib), 32'(it.nib));
        end else begin
          check(it.name, 32'({bus.uio_oe, bus.uio_out, bus.uo_out} & it.mask),
                32'(it.val & it.mask));
        end
      end
    end
  end

  task automatic push_now(input string n, input int at, input logic [23:0] mask,
                          input logic [23:0] val);
    item_t it;
    it = '{name: n, at_edge: at, is_duty: 1'b0, mask: mask, val: val,
           duty: 0, nib: 4'h0};
    sb.push_back(it);
  endtask

  task automatic push_duty(input string n, input int at, input int duty,
                           input logic [3:0] nib);
    item_t it;
    it = '{name: n, at_edge: at, is_duty: 1'b1, mask: 24'h0, val: 24'h0,
           duty: duty, nib: nib};
    sb.push_back(it);
  endtask

  task automatic wait_empty(input int limit);
    for (int i = 0; i < limit && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      check("scoreboard_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic wait_cyc(input int target);
    for (int i = 0; i < 5000 && cyc < target; i++) @(negedge clk);
  endtask

  // One strobe pulse; cap is the rising edge that captures the write.
  task automatic wr(input logic [3:0] a, input logic [7:0] d, output int cap);
    @(negedge clk);
    bus.ui_in  = d;
    bus.uio_in = {3'b000, 1'b1, a};
    cap = cyc + 1;
    @(negedge clk);
    bus.uio_in = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n      = 1'b1;
    bus.uio_in = 8'h00;
    bus.ena    = 1'b1;
    @(negedge clk);
    push_now("rst_hold", 0, 24'hFFFFFF, 24'h000000);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
  endtask

  // First mix_reg load strictly after edge e.
  function automatic int next_b(input int e);
    return (e / 256 + 1) * 256;
  endfunction

  function automatic logic [15:0] lfsr_after(input int k);
    logic [15:0] l;
    l = 16'hACE1;
    for (int i = 0; i < k; i++) l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    return l;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          e, e1, e2, m, k, w, s, mx;
    logic        b0, b1, b2;
    logic [15:0] l;

    bus.ena    = 1'b1;
    bus.ui_in  = 8'h00;
    bus.uio_in = 8'h00;

    // Reset state, PWM silent for two full periods.
    do_reset();
    push_now("post_rst", 1, 24'hFFFFFF, 24'h000000);
    push_duty("rst_pwm0", 256, 0, 4'h0);
    push_duty("rst_pwm1", 512, 0, 4'h0);
    wait_empty(700);

    // DC single voice: square at phase 0 -> 255*15>>4 = 239, >>2 = 59.
    wr(4'd2, 8'hF0, e);
    push_duty("dc1", next_b(e) + 256, 59, 4'h3);
    wait_empty(700);

    // Three DC voices: 3*239 = 717, >>2 = 179 = 0xB3.
    wr(4'd5, 8'hF0, e);
    wr(4'd8, 8'hF0, e);
    push_duty("dc3", next_b(e) + 256, 179, 4'hB);
    wait_empty(700);

    // Global mute.
    wr(4'd9, 8'h01, e);
    push_duty("mute", next_b(e) + 256, 0, 4'h0);
    wait_empty(700);

    // Oscillators: freq 0x0800 -> MSB half-period 16; 0x1000 -> 8.
    do_reset();
    wr(4'd0, 8'h00, e);
    wr(4'd1, 8'h08, e1);
    wr(4'd3, 8'h00, e);
    wr(4'd4, 8'h10, e2);
    for (int t = e2 + 1; t <= e2 + 64; t++) begin
      b1 = 1'(((t - e1) >> 4) & 1);
      b2 = 1'(((t - e2) >> 3) & 1);
      push_now("osc", t, 24'hFFFFFF, {16'h0000, 4'h0, 1'b0, b2, b1, 1'b0});
    end
    wait_empty(200);

    // Strobe held for 10 cycles: only the first data byte (0xF0) lands.
    do_reset();
    @(negedge clk);
    bus.uio_in = 8'h12;
    bus.ui_in  = 8'hF0;
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      bus.ui_in = 8'(i * 8'h11);
    end
    e = cyc;
    @(negedge clk);
    bus.uio_in = 8'h00;
    push_duty("strobe", next_b(e) + 256, 59, 4'h3);
    wait_empty(700);

    // ena=0 freezes phase MSB and PWM; a write during the pause still lands.
    do_reset();
    wr(4'd2, 8'hF0, e);
    wait_cyc(19);
    wr(4'd1, 8'h08, e1);
    m = ((((255 - e1) >> 4) & 1) != 0) ? 0 : 59;
    wait_cyc(306);
    bus.ena = 1'b0;
    b0 = ((305 % 256) < m);
    b1 = 1'(((306 - e1) >> 4) & 1);
    for (int t = 307; t <= 326; t++) begin
      push_now("freeze", t, 24'hFFFFFF,
               {16'h0000, 4'(m >> 4), 2'b00, b1, b0});
    end
    wr(4'd9, 8'h01, e);
    wait_cyc(326);
    bus.ena = 1'b1;
    // en_cnt now trails cyc by 20: load at en 512 is cyc 532, checked at 788.
    push_duty("ena_wr", 788, 0, 4'h0);
    wait_empty(700);

    // Noise: freq 0x8000 carries every 2nd cycle, stepping the LFSR.
    do_reset();
    wr(4'd1, 8'h80, e1);
    wr(4'd2, 8'hF3, e2);
    for (int j = 0; j < 4; j++) begin
      k  = (256 * (j + 1) - 1 - e1) / 2;
      l  = lfsr_after(k);
      w  = int'(l[7:0]);
      s  = (w * 15) >> 4;
      mx = s >> 2;
      push_duty("noise", 256 * (j + 2), mx, 4'(mx >> 4));
    end
    wait_empty(1500);

    // Reset in the middle of noise playback clears everything.
    wait_cyc(cyc + 37);
    do_reset();
    push_now("rst_mid", 1, 24'hFFFFFF, 24'h000000);
    push_duty("rst_mid_pwm", 256, 0, 4'h0);
    wait_empty(400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
